// File: rtl/state_1ms_sched.sv
// Replays eight shadow timing params to the 1 ms state machine, then paces N start pulses P ms apart.
// First load 1 cycle after run, first start 9 cycles after run; no backpressure: run/cfg ignored while busy, abort wins.
module state_1ms_sched #(
  parameter int TICKS_PER_MS = 10000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic        run,
  input  logic        abort,
  output logic        load,
  output logic [3:0]  loadchoice,
  output logic [15:0] datain,
  output logic        state_1ms_start,
  output logic [15:0] frame_cnt,
  output logic        busy,
  output logic        done
);
  localparam int TW = $clog2(TICKS_PER_MS);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MS - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'(TICKS_PER_MS - 2);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;

  state_t        state;
  logic [15:0]   param [8];
  logic [15:0]   frame_total;
  logic [15:0]   period_ms;
  logic [15:0]   total_lat;
  logic [15:0]   period_lat;
  logic [15:0]   ms_cnt;
  logic [TW-1:0] tick;
  logic [2:0]    k;
  logic [2:0]    k_nxt;

  assign k_nxt = k + 3'd1;

  // Outputs are registered for the state being entered, so each one lines up with that state's cycle.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state           <= IDLE;
      for (int i = 0; i < 8; i++) param[i] <= '0;
      frame_total     <= '0;
      period_ms       <= '0;
      total_lat       <= '0;
      period_lat      <= '0;
      ms_cnt          <= '0;
      tick            <= '0;
      k               <= '0;
      load            <= 1'b0;
      loadchoice      <= '0;
      datain          <= '0;
      state_1ms_start <= 1'b0;
      frame_cnt       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      load            <= 1'b0;
      loadchoice      <= '0;
      datain          <= '0;
      state_1ms_start <= 1'b0;
      done            <= 1'b0;

      if (cfg_we && state == IDLE) begin
        if (!cfg_addr[3])        param[cfg_addr[2:0]] <= cfg_data;
        else if (cfg_addr == 4'd8) frame_total <= cfg_data;
        else if (cfg_addr == 4'd9) period_ms   <= cfg_data;
      end

      // The start pulse has already gone out, so it is counted even if abort lands on this edge.
      if (state == START) frame_cnt <= frame_cnt + 16'd1;

      if (state != IDLE && abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (run && !abort) begin
              state      <= LOAD;
              busy       <= 1'b1;
              frame_cnt  <= '0;
              total_lat  <= frame_total;
              period_lat <= (period_ms == 16'd0) ? 16'd1 : period_ms;
              k          <= '0;
              load       <= 1'b1;
              loadchoice <= 4'd0;
              datain     <= param[0];
            end
          end
          LOAD: begin
            if (k == 3'd7) begin
              if (total_lat != 16'd0) begin
                state           <= START;
                state_1ms_start <= 1'b1;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              k          <= k_nxt;
              load       <= 1'b1;
              loadchoice <= {1'b0, k_nxt};
              datain     <= param[k_nxt];
            end
          end
          START: begin
            state  <= WAIT;
            tick   <= '0;
            ms_cnt <= '0;
          end
          WAIT: begin
            // START used one cycle of the period, so leave one tick before the final wrap.
            if (ms_cnt == period_lat - 16'd1 && tick == TICK_PRE) begin
              if (frame_cnt < total_lat) begin
                state           <= START;
                state_1ms_start <= 1'b1;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else if (tick == TICK_LAST) begin
              tick   <= '0;
              ms_cnt <= ms_cnt + 16'd1;
            end else begin
              tick <= tick + TW'(1);
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_state_1ms_sched.sv
// Bench for state_1ms_sched: every output event is logged relative to the run edge and
// compared with a schedule computed from the configured values.
module tb_state_1ms_sched;
  localparam int TPM = 10;
  typedef logic [39:0] ev_t;  // {rel cycle[15:0], kind[3:0], loadchoice[3:0], data[15:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        run = 1'b0;
  logic        abort = 1'b0;
  logic        load;
  logic [3:0]  loadchoice;
  logic [15:0] datain;
  logic        state_1ms_start;
  logic [15:0] frame_cnt;
  logic        busy;
  logic        done;

  int   cyc = 0;
  int   t0 = 0;
  int   ntests = 0;
  int   nfail = 0;
  ev_t  obs[$];
  ev_t  exp_q[$];
  logic [15:0] m_param [8];
  logic [15:0] m_total;
  logic [15:0] m_period;
  logic busy_q = 1'b0;

  state_1ms_sched #(.TICKS_PER_MS(TPM)) dut (
    .clk_sys(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .run(run), .abort(abort), .load(load), .loadchoice(loadchoice), .datain(datain),
    .state_1ms_start(state_1ms_start), .frame_cnt(frame_cnt), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int r, input logic [3:0] kd, input logic [3:0] lc, input logic [15:0] d);
    return {16'(r), kd, lc, d};
  endfunction

  // Kinds: 1 load, 2 start, 3 done (data = frame_cnt), 4 busy rise, 5 busy fall, 15 stray load data.
  always @(posedge clk) begin : mon
    int r;
    #2;
    r = cyc + 1 - t0;
    if (busy && !busy_q) obs.push_back(mk(r, 4'd4, 4'd0, 16'd1));
    if (load) obs.push_back(mk(r, 4'd1, loadchoice, datain));
    else if (loadchoice != 4'd0 || datain != 16'd0) obs.push_back(mk(r, 4'd15, loadchoice, datain));
    if (state_1ms_start) obs.push_back(mk(r, 4'd2, 4'd0, 16'd0));
    if (done) obs.push_back(mk(r, 4'd3, 4'd0, frame_cnt));
    if (!busy && busy_q) obs.push_back(mk(r, 4'd5, 4'd0, 16'd0));
    busy_q <= busy;
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_param[i] = '0;
    m_total = '0;
    m_period = '0;
  endtask

  // Reference schedule straight from the timing rules: loads T+1..T+8, starts every P ms from T+9.
  task automatic build_exp();
    int pe, n;
    pe = (m_period == 16'd0) ? 1 : int'(m_period);
    n = int'(m_total);
    exp_q.delete();
    exp_q.push_back(mk(1, 4'd4, 4'd0, 16'd1));
    for (int kk = 0; kk < 8; kk++) exp_q.push_back(mk(1 + kk, 4'd1, 4'(kk), m_param[kk]));
    for (int s = 0; s < n; s++) exp_q.push_back(mk(9 + s * pe * TPM, 4'd2, 4'd0, 16'd0));
    exp_q.push_back(mk(9 + n * pe * TPM, 4'd3, 4'd0, m_total));
    exp_q.push_back(mk(10 + n * pe * TPM, 4'd5, 4'd0, 16'd0));
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d, input bit taken);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (taken) begin
      if (a < 4'd8) m_param[a[2:0]] = d;
      else if (a == 4'd8) m_total = d;
      else if (a == 4'd9) m_period = d;
    end
  endtask

  task automatic pulse_run();
    @(negedge clk);
    run = 1'b1;
    t0 = cyc + 1;
    obs.delete();
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    bit ok;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ntests++;
    if ({load, state_1ms_start, busy, done} !== 4'b0) begin
      nfail++; $display("FAIL reset_flags: got %b, expected 0000", {load, state_1ms_start, busy, done});
    end
    ntests++;
    if (loadchoice !== 4'd0 || datain !== 16'd0) begin
      nfail++; $display("FAIL reset_loadbus: got %h/%h, expected 0/0000", loadchoice, datain);
    end
    ntests++;
    if (frame_cnt !== 16'd0) begin
      nfail++; $display("FAIL reset_frame_cnt: got %0d, expected 0", frame_cnt);
    end
    pulse_run();
    wait_idle(ok);
    ntests++;
    if (!ok) begin nfail++; $display("FAIL reset_run_timeout: busy still %b, expected 0", busy); end
    build_exp();
    ntests++;
    if (obs.size() != exp_q.size()) begin
      nfail++; $display("FAIL reset_run_events: got %0d events, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      ntests++;
      if (obs[i] !== exp_q[i]) begin nfail++; $display("FAIL reset_run_ev%0d: got %h, expected %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_load_replay();
    bit ok;
    for (int kk = 0; kk < 8; kk++) cfg_write(4'(kk), 16'hA000 + 16'(kk * 16), 1'b1);
    cfg_write(4'd8, 16'd3, 1'b1);
    cfg_write(4'd9, 16'd2, 1'b1);
    pulse_run();
    wait_idle(ok);
    ntests++;
    if (!ok) begin nfail++; $display("FAIL replay_timeout: busy still %b, expected 0", busy); end
    build_exp();
    ntests++;
    if (obs.size() != exp_q.size()) begin
      nfail++; $display("FAIL replay_events: got %0d events, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      ntests++;
      if (obs[i] !== exp_q[i]) begin nfail++; $display("FAIL replay_ev%0d: got %h, expected %h", i, obs[i], exp_q[i]); end
    end
    ntests++;
    if (frame_cnt !== 16'd3) begin nfail++; $display("FAIL replay_frame_cnt: got %0d, expected 3", frame_cnt); end
  endtask

  task automatic test_zero_cases();
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) cfg_write(4'd8, 16'd0, 1'b1);
      else begin cfg_write(4'd9, 16'd0, 1'b1); cfg_write(4'd8, 16'd2, 1'b1); end
      pulse_run();
      wait_idle(ok);
      ntests++;
      if (!ok) begin nfail++; $display("FAIL zero%0d_timeout: busy still %b, expected 0", pass, busy); end
      build_exp();
      ntests++;
      if (obs.size() != exp_q.size()) begin
        nfail++; $display("FAIL zero%0d_events: got %0d events, expected %0d", pass, obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
        ntests++;
        if (obs[i] !== exp_q[i]) begin nfail++; $display("FAIL zero%0d_ev%0d: got %h, expected %h", pass, i, obs[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_abort();
    cfg_write(4'd8, 16'd5, 1'b1);
    cfg_write(4'd9, 16'd1, 1'b1);
    pulse_run();
    while (cyc < t0 + 19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (60) @(negedge clk);
    exp_q.delete();
    exp_q.push_back(mk(1, 4'd4, 4'd0, 16'd1));
    for (int kk = 0; kk < 8; kk++) exp_q.push_back(mk(1 + kk, 4'd1, 4'(kk), m_param[kk]));
    exp_q.push_back(mk(9, 4'd2, 4'd0, 16'd0));
    exp_q.push_back(mk(19, 4'd2, 4'd0, 16'd0));
    exp_q.push_back(mk(21, 4'd5, 4'd0, 16'd0));
    ntests++;
    if (obs.size() != exp_q.size()) begin
      nfail++; $display("FAIL abort_events: got %0d events, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      ntests++;
      if (obs[i] !== exp_q[i]) begin nfail++; $display("FAIL abort_ev%0d: got %h, expected %h", i, obs[i], exp_q[i]); end
    end
    ntests++;
    if (frame_cnt !== 16'd2) begin nfail++; $display("FAIL abort_frame_cnt: got %0d, expected 2", frame_cnt); end
  endtask

  task automatic test_priority();
    bit ok;
    @(negedge clk);
    run = 1'b1; abort = 1'b1;
    obs.delete();
    @(negedge clk);
    run = 1'b0; abort = 1'b0;
    repeat (4) @(negedge clk);
    ntests++;
    if (busy !== 1'b0) begin nfail++; $display("FAIL run_abort_busy: got %b, expected 0", busy); end
    ntests++;
    if (obs.size() != 0) begin nfail++; $display("FAIL run_abort_events: got %0d events, expected 0", obs.size()); end
    cfg_write(4'd8, 16'd2, 1'b1);
    cfg_write(4'd9, 16'd1, 1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      pulse_run();
      if (pass == 0) begin
        while (cyc < t0 + 5) @(negedge clk);
        run = 1'b1; @(negedge clk); run = 1'b0;
        while (cyc < t0 + 14) @(negedge clk);
        cfg_write(4'd8, 16'd7, 1'b0);
        while (cyc < t0 + 20) @(negedge clk);
        run = 1'b1; @(negedge clk); run = 1'b0;
      end
      wait_idle(ok);
      ntests++;
      if (!ok) begin nfail++; $display("FAIL busy_run%0d_timeout: busy still %b, expected 0", pass, busy); end
      build_exp();
      ntests++;
      if (obs.size() != exp_q.size()) begin
        nfail++; $display("FAIL busy_run%0d_events: got %0d events, expected %0d", pass, obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
        ntests++;
        if (obs[i] !== exp_q[i]) begin nfail++; $display("FAIL busy_run%0d_ev%0d: got %h, expected %h", pass, i, obs[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_addr_decode();
    bit ok;
    cfg_write(4'd8, 16'd1, 1'b1);
    cfg_write(4'd12, 16'hFFFF, 1'b1);
    for (int a = 10; a < 16; a++) cfg_write(4'(a), 16'($urandom), 1'b1);
    pulse_run();
    wait_idle(ok);
    ntests++;
    if (!ok) begin nfail++; $display("FAIL decode_timeout: busy still %b, expected 0", busy); end
    build_exp();
    ntests++;
    if (obs.size() != exp_q.size()) begin
      nfail++; $display("FAIL decode_events: got %0d events, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      ntests++;
      if (obs[i] !== exp_q[i]) begin nfail++; $display("FAIL decode_ev%0d: got %h, expected %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midwait();
    bit ok;
    cfg_write(4'd8, 16'd3, 1'b1);
    cfg_write(4'd9, 16'd2, 1'b1);
    pulse_run();
    while (cyc < t0 + 14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ntests++;
    if ({load, state_1ms_start, busy, done} !== 4'b0 || loadchoice !== 4'd0 || datain !== 16'd0) begin
      nfail++; $display("FAIL midwait_rst_outputs: got %b %h %h, expected 0000 0 0000",
                        {load, state_1ms_start, busy, done}, loadchoice, datain);
    end
    ntests++;
    if (frame_cnt !== 16'd0) begin nfail++; $display("FAIL midwait_rst_frame_cnt: got %0d, expected 0", frame_cnt); end
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    pulse_run();
    wait_idle(ok);
    ntests++;
    if (!ok) begin nfail++; $display("FAIL midwait_timeout: busy still %b, expected 0", busy); end
    build_exp();
    ntests++;
    if (obs.size() != exp_q.size()) begin
      nfail++; $display("FAIL midwait_events: got %0d events, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      ntests++;
      if (obs[i] !== exp_q[i]) begin nfail++; $display("FAIL midwait_ev%0d: got %h, expected %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int a;
    for (int it = 0; it < 6; it++) begin
      repeat (3) begin
        a = $urandom_range(0, 13);
        if (a >= 8) a = a + 2;
        cfg_write(4'(a), 16'($urandom), 1'b1);
      end
      cfg_write(4'd8, 16'($urandom_range(0, 4)), 1'b1);
      cfg_write(4'd9, 16'($urandom_range(0, 3)), 1'b1);
      pulse_run();
      wait_idle(ok);
      ntests++;
      if (!ok) begin nfail++; $display("FAIL rand%0d_timeout: busy still %b, expected 0", it, busy); end
      build_exp();
      ntests++;
      if (obs.size() != exp_q.size()) begin
        nfail++; $display("FAIL rand%0d_events: got %0d events, expected %0d", it, obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
        ntests++;
        if (obs[i] !== exp_q[i]) begin nfail++; $display("FAIL rand%0d_ev%0d: got %h, expected %h", it, i, obs[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_replay();
    test_zero_cases();
    test_abort();
    test_priority();
    test_addr_decode();
    test_reset_midwait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
